// File: rtl/p405s_gpr_pkg.sv
// rtl/p405s_gpr_pkg.sv - shared constants and stage record for the GPR write-port controller
package p405s_gpr_pkg;

  localparam int ADDR_W_DEF = 10;

  // One pipeline stage's destination tracking: target GPR and which port will write it
  typedef struct packed {
    logic [0:ADDR_W_DEF-1] addr;
    logic                  rpVld;
    logic                  lpVld;
  } gpr_stage_t;

endpackage

// File: rtl/p405s_gpr_addr_cmp.sv
// rtl/p405s_gpr_addr_cmp.sv - valid-gated GPR address equality comparator
module p405s_gpr_addr_cmp #(
  parameter int ADDR_W = p405s_gpr_pkg::ADDR_W_DEF
) (
  input  logic              vld_i,
  input  logic [0:ADDR_W-1] a_i,
  input  logic [0:ADDR_W-1] b_i,
  output logic              eq_o
);

  assign eq_o = vld_i & (a_i == b_i);

endmodule

// File: rtl/p405s_gpr_wr_port_ctl.sv
// rtl/p405s_gpr_wr_port_ctl.sv - exe/wb/lwb destination tracking, Rp/Lp write ports, load stall; option macro P405S_MORM_FWD_EN
module p405s_gpr_wr_port_ctl
  import p405s_gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CB,
  input  logic              resetCore,
  input  logic              dcdVld,
  input  logic              dcdHold,
  input  logic [0:ADDR_W-1] dcdRtAddr,
  input  logic              dcdRpWrEn,
  input  logic              dcdLpWrEn,
  input  logic              exeHold,
  input  logic              exeMulti,
  input  logic              exeFlush,
  input  logic              ldDataVld,
  input  logic [0:ADDR_W-1] preDcdRA,
  input  logic [0:ADDR_W-1] preDcdRB,
  output logic              dcdRAEqexeRpAddr,
  output logic              dcdRAEqexeMorMRpAddr,
  output logic              dcdRAEqwbRpAddr,
  output logic              dcdRAEqwbLpAddr,
  output logic              dcdRAEqlwbLpAddr,
  output logic              dcdRBEqexeRpAddr,
  output logic              dcdRBEqexeMorMRpAddr,
  output logic              dcdRBEqwbRpAddr,
  output logic              dcdRBEqwbLpAddr,
  output logic              dcdRBEqlwbLpAddr,
  output logic              gprRpWrEn,
  output logic [0:ADDR_W-1] gprRpWrAddr,
  output logic              gprLpWrEn,
  output logic [0:ADDR_W-1] gprLpWrAddr,
  output logic              ldStall
);

  gpr_stage_t        exe_q, exe_d;
  gpr_stage_t        wb_q, wb_d;
  logic [0:ADDR_W-1] lwbAddr_q, lwbAddr_d;
  logic              lwbVld_q, lwbVld_d;
  logic              adv;
  logic              issue_ok;

  // A new load cannot enter wb while an older one is still waiting for data,
  // which keeps lwb at one entry.
  assign ldStall  = exe_q.lpVld & (lwbVld_q | (wb_q.lpVld & ~ldDataVld));
  assign adv      = ~exeHold & ~ldStall;
  assign issue_ok = dcdVld & ~dcdHold;

  // exe stage: flush beats hold; otherwise capture decode when the pipe advances
  always_comb begin
    exe_d = exe_q;
    if (exeFlush) begin
      exe_d.rpVld = 1'b0;
      exe_d.lpVld = 1'b0;
    end else if (adv) begin
      exe_d.addr  = dcdRtAddr;
      exe_d.rpVld = issue_ok & dcdRpWrEn;
      exe_d.lpVld = issue_ok & dcdLpWrEn;
    end
  end

  // wb stage: take exe on advance, otherwise a bubble so nothing is written twice
  always_comb begin
    wb_d = '0;
    if (adv & ~exeFlush) begin
      wb_d = exe_q;
    end
  end

  // lwb: park a wb load that got no data; release it on its data beat
  always_comb begin
    lwbVld_d  = lwbVld_q;
    lwbAddr_d = lwbAddr_q;
    if (lwbVld_q & ldDataVld) begin
      lwbVld_d = 1'b0;
    end else if (wb_q.lpVld & ~ldDataVld) begin
      lwbVld_d  = 1'b1;
      lwbAddr_d = wb_q.addr;
    end
  end

  // Stage registers; reset drops everything including a parked load
  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      exe_q     <= '0;
      wb_q      <= '0;
      lwbAddr_q <= '0;
      lwbVld_q  <= 1'b0;
    end else begin
      exe_q     <= exe_d;
      wb_q      <= wb_d;
      lwbAddr_q <= lwbAddr_d;
      lwbVld_q  <= lwbVld_d;
    end
  end

  assign gprRpWrEn   = wb_q.rpVld;
  assign gprRpWrAddr = wb_q.addr;

  // Lp port: the parked (older) load always has priority over the wb load
  always_comb begin
    gprLpWrEn   = 1'b0;
    gprLpWrAddr = '0;
    if (lwbVld_q & ldDataVld) begin
      gprLpWrEn   = 1'b1;
      gprLpWrAddr = lwbAddr_q;
    end else if (wb_q.lpVld & ldDataVld) begin
      gprLpWrEn   = 1'b1;
      gprLpWrAddr = wb_q.addr;
    end
  end

  // Comparator inputs, stage order: exeRp, exeMorMRp, wbRp, wbLp, lwbLp
  logic [0:ADDR_W-1] st_addr [5];
  logic [4:0]        st_vld;
  logic [4:0]        eq_ra;
  logic [4:0]        eq_rb;

`ifdef P405S_MORM_FWD_EN
  assign st_vld[1] = exe_q.rpVld & exeMulti;
`else
  logic unused_exeMulti;
  assign unused_exeMulti = exeMulti;
  assign st_vld[1]       = 1'b0;
`endif

  assign st_vld[0]  = exe_q.rpVld;
  assign st_vld[2]  = wb_q.rpVld;
  assign st_vld[3]  = wb_q.lpVld;
  assign st_vld[4]  = lwbVld_q;
  assign st_addr[0] = exe_q.addr;
  assign st_addr[1] = exe_q.addr;
  assign st_addr[2] = wb_q.addr;
  assign st_addr[3] = wb_q.addr;
  assign st_addr[4] = lwbAddr_q;

  for (genvar s = 0; s < 5; s++) begin : g_cmp
    p405s_gpr_addr_cmp #(.ADDR_W(ADDR_W)) u_ra (
      .vld_i(st_vld[s]), .a_i(preDcdRA), .b_i(st_addr[s]), .eq_o(eq_ra[s])
    );
    p405s_gpr_addr_cmp #(.ADDR_W(ADDR_W)) u_rb (
      .vld_i(st_vld[s]), .a_i(preDcdRB), .b_i(st_addr[s]), .eq_o(eq_rb[s])
    );
  end

  assign dcdRAEqexeRpAddr     = eq_ra[0];
  assign dcdRAEqexeMorMRpAddr = eq_ra[1];
  assign dcdRAEqwbRpAddr      = eq_ra[2];
  assign dcdRAEqwbLpAddr      = eq_ra[3];
  assign dcdRAEqlwbLpAddr     = eq_ra[4];
  assign dcdRBEqexeRpAddr     = eq_rb[0];
  assign dcdRBEqexeMorMRpAddr = eq_rb[1];
  assign dcdRBEqwbRpAddr      = eq_rb[2];
  assign dcdRBEqwbLpAddr      = eq_rb[3];
  assign dcdRBEqlwbLpAddr     = eq_rb[4];

endmodule

// File: tb/tb_p405s_gpr_wr_port_ctl.sv
// tb/tb_p405s_gpr_wr_port_ctl.sv - scoreboard bench for the GPR write-port controller
module tb_p405s_gpr_wr_port_ctl;
  localparam int AW = 10;

  logic          CB = 1'b0;
  logic          resetCore, dcdVld, dcdHold, dcdRpWrEn, dcdLpWrEn;
  logic          exeHold, exeMulti, exeFlush, ldDataVld;
  logic [0:AW-1] dcdRtAddr, preDcdRA, preDcdRB;
  logic          raExeRp, raExeM, raWbRp, raWbLp, raLwb;
  logic          rbExeRp, rbExeM, rbWbRp, rbWbLp, rbLwb;
  logic          gprRpWrEn, gprLpWrEn, ldStall;
  logic [0:AW-1] gprRpWrAddr, gprLpWrAddr;

  typedef struct {
    logic [0:AW-1] addr;
    int            cyc;
  } wr_t;

  wr_t rp_q[$];
  wr_t lp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

`ifdef P405S_MORM_FWD_EN
  localparam logic MORM_EXP = 1'b1;
`else
  localparam logic MORM_EXP = 1'b0;
`endif

  always #5 CB = ~CB;
  always @(posedge CB) cyc <= cyc + 1;

  p405s_gpr_wr_port_ctl #(.ADDR_W(AW)) dut (
    .CB(CB), .resetCore(resetCore), .dcdVld(dcdVld), .dcdHold(dcdHold),
    .dcdRtAddr(dcdRtAddr), .dcdRpWrEn(dcdRpWrEn), .dcdLpWrEn(dcdLpWrEn),
    .exeHold(exeHold), .exeMulti(exeMulti), .exeFlush(exeFlush), .ldDataVld(ldDataVld),
    .preDcdRA(preDcdRA), .preDcdRB(preDcdRB),
    .dcdRAEqexeRpAddr(raExeRp), .dcdRAEqexeMorMRpAddr(raExeM), .dcdRAEqwbRpAddr(raWbRp),
    .dcdRAEqwbLpAddr(raWbLp), .dcdRAEqlwbLpAddr(raLwb),
    .dcdRBEqexeRpAddr(rbExeRp), .dcdRBEqexeMorMRpAddr(rbExeM), .dcdRBEqwbRpAddr(rbWbRp),
    .dcdRBEqwbLpAddr(rbWbLp), .dcdRBEqlwbLpAddr(rbLwb),
    .gprRpWrEn(gprRpWrEn), .gprRpWrAddr(gprRpWrAddr),
    .gprLpWrEn(gprLpWrEn), .gprLpWrAddr(gprLpWrAddr), .ldStall(ldStall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic issue(input logic [0:AW-1] a, input logic rp, input logic lp);
    dcdVld    = 1'b1;
    dcdRtAddr = a;
    dcdRpWrEn = rp;
    dcdLpWrEn = lp;
  endtask

  task automatic idle();
    dcdVld    = 1'b0;
    dcdRpWrEn = 1'b0;
    dcdLpWrEn = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the head of its queue
  always @(negedge CB) begin
    wr_t w;
    if (!resetCore) begin
      if (gprRpWrEn) begin
        if (rp_q.size() == 0) chk("rp_unexpected_write", gprRpWrEn, 0);
        else begin
          w = rp_q.pop_front();
          chk("rp_addr", gprRpWrAddr, w.addr);
          chk("rp_cycle", cyc, w.cyc);
        end
      end
      if (gprLpWrEn) begin
        if (lp_q.size() == 0) chk("lp_unexpected_write", gprLpWrEn, 0);
        else begin
          w = lp_q.pop_front();
          chk("lp_addr", gprLpWrAddr, w.addr);
          chk("lp_cycle", cyc, w.cyc);
        end
      end else begin
        chk("lp_addr_idle_zero", gprLpWrAddr, 0);
      end
      if (dut.wb_q.lpVld && dut.lwbVld_q && ldDataVld)
        chk("env_wb_lwb_load_collision", 1'b1, 1'b0 ^ ldDataVld ^ 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetCore = 1'b1; dcdHold = 1'b0; exeHold = 1'b0; exeMulti = 1'b0; exeFlush = 1'b0;
    ldDataVld = 1'b0; preDcdRA = '0; preDcdRB = '0; dcdRtAddr = '0;
    idle();
    #3;
    chk("rst_rp_en", gprRpWrEn, 0);
    chk("rst_rp_addr", gprRpWrAddr, 0);
    chk("rst_lp_en", gprLpWrEn, 0);
    chk("rst_stall", ldStall, 0);
    chk("rst_flags", {raExeRp, raExeM, raWbRp, raWbLp, raLwb, rbExeRp, rbExeM, rbWbRp, rbWbLp, rbLwb}, 0);
    tick(); tick();
    resetCore = 1'b0;
    tick();

    // ALU pass-through, 2-cycle latency, RB forwarding flags
    issue(10'h005, 1, 0); rp_q.push_back('{addr: 10'h005, cyc: cyc + 2});
    tick(); idle(); preDcdRB = 10'h005;
    #2 chk("t1_rb_eq_exe_rp", rbExeRp, 1);
    chk("t1_ra_eq_exe_rp", raExeRp, 0);
    tick();
    #2 chk("t1_rb_eq_wb_rp", rbWbRp, 1);
    chk("t1_rb_eq_exe_rp_gone", rbExeRp, 0);
    tick();

    // Back-to-back Rp ops with boundary addresses
    issue(10'h001, 1, 0); rp_q.push_back('{addr: 10'h001, cyc: cyc + 2}); tick();
    issue(10'h3FF, 1, 0); rp_q.push_back('{addr: 10'h3FF, cyc: cyc + 2}); tick();
    issue(10'h200, 1, 0); rp_q.push_back('{addr: 10'h200, cyc: cyc + 2}); tick();
    idle(); tick(); tick();

    // Load hit in wb
    issue(10'h00A, 0, 1); tick(); idle(); tick();
    ldDataVld = 1'b1; lp_q.push_back('{addr: 10'h00A, cyc: cyc}); preDcdRA = 10'h00A;
    #2 chk("t2_ra_eq_wb_lp", raWbLp, 1);
    chk("t2_no_stall", ldStall, 0);
    tick(); ldDataVld = 1'b0;
    #2 chk("t2_lwb_empty", raLwb, 0);
    chk("t2_wb_lp_gone", raWbLp, 0);
    tick();

    // Load miss followed by a back-to-back load
    issue(10'h00A, 0, 1); tick();
    issue(10'h00B, 0, 1); tick(); idle();
    #2 chk("t3_stall_wb_miss", ldStall, 1);
    tick();
    #2 chk("t3_ra_eq_lwb", raLwb, 1);
    chk("t3_stall_lwb", ldStall, 1);
    ldDataVld = 1'b1; lp_q.push_back('{addr: 10'h00A, cyc: cyc});
    tick(); ldDataVld = 1'b0; preDcdRB = 10'h00B;
    #2 chk("t3_stall_released", ldStall, 0);
    chk("t3_wb_bubble", rbWbLp, 0);
    chk("t3_lwb_cleared", raLwb, 0);
    tick();
    ldDataVld = 1'b1; lp_q.push_back('{addr: 10'h00B, cyc: cyc});
    #2 chk("t3_rb_eq_wb_lp", rbWbLp, 1);
    tick(); ldDataVld = 1'b0; tick();

    // Plain exe hold delays the Rp write by one cycle
    issue(10'h009, 1, 0); rp_q.push_back('{addr: 10'h009, cyc: cyc + 3});
    tick(); idle(); exeHold = 1'b1; preDcdRA = 10'h009;
    tick(); exeHold = 1'b0;
    #2 chk("t4_held_in_exe", raExeRp, 1);
    chk("t4_wb_bubble", raWbRp, 0);
    tick(); tick();

    // Flush together with hold: never written
    issue(10'h007, 1, 0); tick(); idle();
    exeHold = 1'b1; exeFlush = 1'b1; preDcdRB = 10'h007;
    #2 chk("t4_pre_flush_exe", rbExeRp, 1);
    tick(); exeHold = 1'b0; exeFlush = 1'b0;
    #2 chk("t4_flushed_exe", rbExeRp, 0);
    chk("t4_flush_wb_bubble", rbWbRp, 0);
    chk("t4_flush_no_write", gprRpWrEn, 0);
    tick(); tick();

    // Multi-cycle op forwarding flag
    issue(10'h00C, 1, 0); rp_q.push_back('{addr: 10'h00C, cyc: cyc + 2});
    tick(); idle(); exeMulti = 1'b1; preDcdRA = 10'h00C;
    #2 chk("t5_ra_morm", raExeM, MORM_EXP);
    chk("t5_rb_morm_nomatch", rbExeM, 0);
    chk("t5_ra_exe_rp", raExeRp, 1);
    tick(); exeMulti = 1'b0; tick();

    // Reset while a load is parked in lwb
    issue(10'h00D, 0, 1); tick(); idle(); tick(); tick();
    preDcdRA = 10'h00D;
    #2 chk("t6_lwb_parked", raLwb, 1);
    resetCore = 1'b1;
    #1 chk("t6_rst_lwb_flag", raLwb, 0);
    chk("t6_rst_lp_en", gprLpWrEn, 0);
    chk("t6_rst_stall", ldStall, 0);
    tick(); resetCore = 1'b0; ldDataVld = 1'b1;
    #2 chk("t6_no_write_after_rst", gprLpWrEn, 0);
    tick(); ldDataVld = 1'b0; tick(); tick();

    chk("rp_queue_drained", rp_q.size(), 0);
    chk("lp_queue_drained", lp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
